// File: rtl/nrisc_ula_if.sv
// Operand/result bundle of the NRISC ULA; the datapath drives it as master,
// the ULA answers as slave.
interface nrisc_ula_if #(parameter int TAM = 16);
  logic [TAM-1:0] ULA_A;
  logic [TAM-1:0] ULA_B;
  logic           incdec;
  logic [3:0]     ULA_ctrl;
  logic [TAM-1:0] ULA_OUT;
  logic [2:0]     ULA_flags;
  logic [2:0]     ULA_flags_q;

  modport master (
    output ULA_A, ULA_B, incdec, ULA_ctrl,
    input  ULA_OUT, ULA_flags, ULA_flags_q
  );

  modport slave (
    input  ULA_A, ULA_B, incdec, ULA_ctrl,
    output ULA_OUT, ULA_flags, ULA_flags_q
  );
endinterface

// File: rtl/nrisc_ula.sv
// NRISC ULA: combinational TAM-bit ALU with {minus, zero, carry} flags and a
// registered copy of the flags for the status register.
module nrisc_ula #(
  parameter int TAM = 16
) (
  input logic        clk,
  input logic        rst,
  nrisc_ula_if.slave ula
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SHR = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_NOT = 4'b0111;
  localparam logic [3:0] OP_RTR = 4'b1101;
  localparam logic [3:0] OP_RTL = 4'b1110;

  localparam logic [TAM-1:0] ONE = {{(TAM-1){1'b0}}, 1'b1};

  logic [TAM-1:0] a, bx, res;
  logic [TAM:0]   sum_x, dif_x;
  logic           minus, carry, zero, use_one;

  assign a       = ula.ULA_A;
  assign use_one = ula.incdec && (ula.ULA_ctrl == OP_ADD || ula.ULA_ctrl == OP_SUB);
  assign bx      = use_one ? ONE : ula.ULA_B;

  // Sign-extended by one bit so the MSB of each is the sign of the exact result.
  assign sum_x = {a[TAM-1], a} + {bx[TAM-1], bx};
  assign dif_x = {a[TAM-1], a} - {bx[TAM-1], bx};

  always_comb begin
    res   = '0;
    minus = 1'b0;
    carry = 1'b0;
    case (ula.ULA_ctrl)
      OP_ADD: begin
        res   = sum_x[TAM-1:0];
        minus = sum_x[TAM];
        carry = a[TAM-1] ^ bx[TAM-1] ^ sum_x[TAM-1];
      end
      OP_SUB: begin
        res   = dif_x[TAM-1:0];
        minus = dif_x[TAM];
        carry = (bx != '0) && !(a[TAM-1] ^ bx[TAM-1] ^ dif_x[TAM-1]);
      end
      OP_AND: res = a & ula.ULA_B;
      OP_OR:  res = a | ula.ULA_B;
      OP_XOR: res = a ^ ula.ULA_B;
      OP_SHR: begin
        res   = {a[TAM-1], a[TAM-1:1]};
        carry = a[0];
      end
      OP_RTR: res = {a[0], a[TAM-1:1]};
      OP_SHL: begin
        res   = {a[TAM-2:0], 1'b0};
        carry = a[TAM-1];
      end
      OP_RTL: res = {a[TAM-2:0], a[TAM-1]};
      OP_NOT: res = ~a;
      default: res = '0;
    endcase
  end

  assign zero          = (res == '0);
  assign ula.ULA_OUT   = res;
  assign ula.ULA_flags = {minus, zero, carry};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ula.ULA_flags_q <= 3'b000;
    else      ula.ULA_flags_q <= {minus, zero, carry};
  end

endmodule

// File: tb/tb_nrisc_ula.sv
// Directed and randomized checks of nrisc_ula against an integer-arithmetic model.
module tb_nrisc_ula;
  localparam int TAM = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  nrisc_ula_if #(.TAM(TAM)) bus ();
  nrisc_ula #(.TAM(TAM)) dut (.clk(clk), .rst(rst), .ula(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: plain signed integer arithmetic on the operation rules.
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                input logic inc, input logic [3:0] c,
                                output logic [15:0] o, output logic [2:0] f);
    int sa, sb, r, t;
    logic [15:0] bx;
    logic mn, cy;
    bx = (inc && (c == 4'd0 || c == 4'd1)) ? 16'd1 : b;
    sa = int'($signed(a));
    sb = int'($signed(bx));
    mn = 1'b0; cy = 1'b0; o = 16'h0000;
    case (c)
      4'd0: begin
        r = sa + sb; o = r[15:0]; mn = (r < 0);
        t = int'(a & 16'h7fff) + int'(bx & 16'h7fff); cy = (t >= 32768);
      end
      4'd1: begin
        r = sa - sb; o = r[15:0]; mn = (r < 0);
        t = int'(a & 16'h7fff) + int'((~bx) & 16'h7fff) + 1; cy = (t >= 32768) && (bx != 0);
      end
      4'd2: o = a & b;
      4'd3: o = a | b;
      4'd4: o = a ^ b;
      4'd5: begin o = 16'(sa / 2 - ((sa < 0 && (sa % 2) != 0) ? 1 : 0)); cy = a[0]; end
      4'd13: o = 16'((int'(a) / 2) + (a[0] ? 32768 : 0));
      4'd6: begin o = 16'((int'(a) * 2) % 65536); cy = (a >= 16'h8000); end
      4'd14: o = 16'((int'(a) * 2) % 65536 + (a >= 16'h8000 ? 1 : 0));
      4'd7: o = 16'(65535 - int'(a));
      default: o = 16'h0000;
    endcase
    f = {mn, (o == 16'h0000), cy};
  endfunction

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic inc, input logic [3:0] c);
    bus.ULA_A = a; bus.ULA_B = b; bus.incdec = inc; bus.ULA_ctrl = c;
  endtask

  task automatic dir(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic inc, input logic [3:0] c,
                     input logic [15:0] eo, input logic [2:0] ef);
    drive(a, b, inc, c);
    #1;
    check({tag, "_out"}, bus.ULA_OUT, eo);
    check({tag, "_flg"}, {13'd0, bus.ULA_flags}, {13'd0, ef});
  endtask

  initial begin
    logic [15:0] ra, rb, eo;
    logic [2:0]  ef;
    logic        ri;
    logic [3:0]  rc;

    drive(16'h0, 16'h0, 1'b0, 4'd0);
    #2;
    check("reset_q", {13'd0, bus.ULA_flags_q}, 16'd0);
    @(negedge clk); rst = 1'b1;

    dir("add_ovf",  16'h7fff, 16'h0001, 1'b0, 4'b0000, 16'h8000, 3'b001);
    dir("add_wrap", 16'hffff, 16'h0001, 1'b0, 4'b0000, 16'h0000, 3'b011);
    dir("add_min",  16'h8000, 16'h8000, 1'b0, 4'b0000, 16'h0000, 3'b110);
    dir("sub_neg",  16'h0005, 16'h0007, 1'b0, 4'b0001, 16'hfffe, 3'b100);
    dir("sub_b0",   16'h1234, 16'h0000, 1'b0, 4'b0001, 16'h1234, 3'b000);
    dir("sub_pos",  16'h0007, 16'h0005, 1'b0, 4'b0001, 16'h0002, 3'b001);
    dir("inc",      16'h00ff, 16'h1234, 1'b1, 4'b0000, 16'h0100, 3'b000);
    dir("dec",      16'h0001, 16'h5555, 1'b1, 4'b0001, 16'h0000, 3'b011);
    dir("and_inc",  16'hf0f0, 16'h0ff0, 1'b1, 4'b0010, 16'h00f0, 3'b000);
    dir("shr",      16'h8001, 16'h0000, 1'b0, 4'b0101, 16'hc000, 3'b001);
    dir("rtr",      16'h8001, 16'h0000, 1'b0, 4'b1101, 16'hc000, 3'b000);
    dir("shl",      16'h8001, 16'h0000, 1'b0, 4'b0110, 16'h0002, 3'b001);
    dir("rtl",      16'h8001, 16'h0000, 1'b0, 4'b1110, 16'h0003, 3'b000);
    dir("not",      16'h8001, 16'h0000, 1'b0, 4'b0111, 16'h7ffe, 3'b000);
    dir("and",      16'hf0f0, 16'h0f0f, 1'b0, 4'b0010, 16'h0000, 3'b010);
    dir("or",       16'hf0f0, 16'h0f0f, 1'b0, 4'b0011, 16'hffff, 3'b000);
    dir("xor",      16'hffff, 16'hffff, 1'b0, 4'b0100, 16'h0000, 3'b010);
    dir("unused",   16'h1234, 16'h5678, 1'b0, 4'b1000, 16'h0000, 3'b010);
    dir("unused_f", 16'hffff, 16'hffff, 1'b1, 4'b1111, 16'h0000, 3'b010);

    // Register: load nonzero flags, then async clear mid-cycle.
    @(negedge clk); drive(16'h0005, 16'h0007, 1'b0, 4'b0001);
    @(posedge clk); #1;
    check("q_load", {13'd0, bus.ULA_flags_q}, 16'd4);
    #2; rst = 1'b0; #1;
    check("q_async", {13'd0, bus.ULA_flags_q}, 16'd0);
    @(posedge clk); #1;
    check("q_hold", {13'd0, bus.ULA_flags_q}, 16'd0);
    @(negedge clk); rst = 1'b1; drive(16'hffff, 16'h0001, 1'b0, 4'b0000);
    #1;
    check("q_pre", {13'd0, bus.ULA_flags_q}, 16'd0);
    @(posedge clk); #1;
    check("q_post", {13'd0, bus.ULA_flags_q}, 16'd3);

    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 7))
        0: ra = 16'h0000;
        1: rb = 16'h0000;
        2: rb = ra;
        3: ra = 16'h8000;
        default: ;
      endcase
      ri = 1'($urandom);
      rc = 4'($urandom_range(0, 15));
      drive(ra, rb, ri, rc);
      model(ra, rb, ri, rc, eo, ef);
      #1;
      check("rnd_out", bus.ULA_OUT, eo);
      check("rnd_flg", {13'd0, bus.ULA_flags}, {13'd0, ef});
      @(posedge clk); #1;
      check("rnd_q", {13'd0, bus.ULA_flags_q}, {13'd0, ef});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
